// File: rtl/rgb_to_gray_streamer_pkg.sv
// Shared constants and types for the RGB-to-gray streamer.
package rgb_to_gray_streamer_pkg;

    localparam int R_MSB = 23;
    localparam int G_MSB = 15;
    localparam int B_MSB = 7;

    localparam int DEF_COEF_R = 77;
    localparam int DEF_COEF_G = 150;
    localparam int DEF_COEF_B = 29;

    typedef struct packed {
        logic [15:0] r;
        logic [15:0] g;
        logic [15:0] b;
    } prod_t;

    function automatic int pix_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rgb_to_gray_streamer_gray_pipe_stage.sv
// Generic valid/ready register slice; loads when enabled, flushed by clear.
module gray_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             adv,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/rgb_to_gray_streamer.sv
// RGB888 to 8-bit luma, 2-stage valid/ready pipeline with per-frame pixel count.
// Define GRAY_ROUND_EN for round-half-up instead of truncation.
module rgb_to_gray_streamer
    import rgb_to_gray_streamer_pkg::*;
#(
    parameter int IMG_X_SIZE = 3,
    parameter int IMG_Y_SIZE = 3,
    parameter int COEF_R     = DEF_COEF_R,
    parameter int COEF_G     = DEF_COEF_G,
    parameter int COEF_B     = DEF_COEF_B
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [23:0] RgbPixel_i,
    input  logic        rgbValid_i,
    output logic        rgbReady_o,
    input  logic        frameClear_i,
    output logic [7:0]  GrayPixel_o,
    output logic        grayValid_o,
    input  logic        grayReady_i,
    output logic        lastPixel_o,
    output logic        frameDone_o
);

    localparam int PIXELS = IMG_X_SIZE * IMG_Y_SIZE;
    localparam int CW = pix_cnt_w(PIXELS);
    localparam logic [CW-1:0] LAST_IDX = CW'(PIXELS - 1);
    localparam logic [15:0] CR = 16'(COEF_R);
    localparam logic [15:0] CG = 16'(COEF_G);
    localparam logic [15:0] CB = 16'(COEF_B);

    logic          s1_valid;
    prod_t         s1_prod;
    prod_t         prod;
    logic [15:0]   sum;
    logic          adv1;
    logic          adv2;
    logic          out_xfer;
    logic          at_last;
    logic [CW-1:0] count;

    assign adv2       = !grayValid_o | grayReady_i;
    assign adv1       = !s1_valid | adv2;
    assign rgbReady_o = adv1 & !frameClear_i;

    assign prod.r = 16'(RgbPixel_i[R_MSB -: 8]) * CR;
    assign prod.g = 16'(RgbPixel_i[G_MSB -: 8]) * CG;
    assign prod.b = 16'(RgbPixel_i[B_MSB -: 8]) * CB;

`ifdef GRAY_ROUND_EN
    assign sum = s1_prod.r + s1_prod.g + s1_prod.b + 16'd128;
`else
    assign sum = s1_prod.r + s1_prod.g + s1_prod.b;
`endif

    gray_pipe_stage #(.WIDTH($bits(prod_t))) u_stage1 (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .clear     (frameClear_i),
        .adv       (adv1),
        .in_valid  (rgbValid_i & rgbReady_o),
        .in_data   (prod),
        .out_valid (s1_valid),
        .out_data  (s1_prod)
    );

    gray_pipe_stage #(.WIDTH(8)) u_stage2 (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .clear     (frameClear_i),
        .adv       (adv2),
        .in_valid  (s1_valid),
        .in_data   (sum[15:8]),
        .out_valid (grayValid_o),
        .out_data  (GrayPixel_o)
    );

    assign at_last     = (count == LAST_IDX);
    assign out_xfer    = grayValid_o & grayReady_i;
    assign lastPixel_o = grayValid_o & at_last;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count       <= '0;
            frameDone_o <= 1'b0;
        end else if (frameClear_i) begin
            count       <= '0;
            frameDone_o <= 1'b0;
        end else begin
            frameDone_o <= out_xfer & at_last;
            if (out_xfer) begin
                count <= at_last ? '0 : count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rgb_to_gray_streamer.sv
// Directed self-checking bench for rgb_to_gray_streamer (3x3 frame, default coefficients).
module tb_rgb_to_gray_streamer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [23:0] RgbPixel_i;
    logic        rgbValid_i;
    logic        rgbReady_o;
    logic        frameClear_i;
    logic [7:0]  GrayPixel_o;
    logic        grayValid_o;
    logic        grayReady_i;
    logic        lastPixel_o;
    logic        frameDone_o;

    int vectors = 0;
    int miscompares = 0;

`ifdef GRAY_ROUND_EN
    localparam logic [7:0] EXP_RED  = 8'd77;
    localparam logic [7:0] EXP_BLUE = 8'd29;
`else
    localparam logic [7:0] EXP_RED  = 8'd76;
    localparam logic [7:0] EXP_BLUE = 8'd28;
`endif

    rgb_to_gray_streamer #(
        .IMG_X_SIZE (3),
        .IMG_Y_SIZE (3)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .RgbPixel_i   (RgbPixel_i),
        .rgbValid_i   (rgbValid_i),
        .rgbReady_o   (rgbReady_o),
        .frameClear_i (frameClear_i),
        .GrayPixel_o  (GrayPixel_o),
        .grayValid_o  (grayValid_o),
        .grayReady_i  (grayReady_i),
        .lastPixel_o  (lastPixel_o),
        .frameDone_o  (frameDone_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; one pixel with grayReady_i held high.
    task automatic single(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic [7:0] exp, input string tag);
        RgbPixel_i  = {r, g, b};
        rgbValid_i  = 1'b1;
        grayReady_i = 1'b1;
        #1 chk({tag, "_ready"}, rgbReady_o, 1);
        @(posedge clk_i); #1;
        rgbValid_i = 1'b0;
        chk({tag, "_lat1_valid"}, grayValid_o, 0);
        @(posedge clk_i); #1;
        chk({tag, "_lat2_valid"}, grayValid_o, 1);
        chk({tag, "_gray"}, GrayPixel_o, exp);
        chk({tag, "_last"}, lastPixel_o, 0);
        @(posedge clk_i); #1;
        chk({tag, "_drained"}, grayValid_o, 0);
    endtask

    // Streams n gray-valued pixels (R=G=B=v gives luma v in both rounding modes).
    // mode 0: grayReady_i always 1; mode 1: ready pattern 1,0,0 repeating.
    task automatic run_stream(input int n, input int mode, output int dones,
                              output int gap, output int low_ready);
        int sent = 0;
        int got = 0;
        int occ = 0;
        int cyc = 0;
        int last_done = -1;
        logic prev_last = 1'b0;
        logic in_x, out_x;
        logic [7:0] v;
        logic [7:0] q[$];
        dones = 0;
        gap = 0;
        low_ready = 0;
        while ((got < n || prev_last) && cyc < 300) begin
            chk("frame_done", frameDone_o, prev_last);
            if (frameDone_o) begin
                if (last_done >= 0) gap = cyc - last_done;
                last_done = cyc;
                dones++;
            end
            grayReady_i = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            v = 8'((sent * 7 + 3) & 255);
            rgbValid_i = (sent < n);
            RgbPixel_i = {v, v, v};
            #1;
            chk("stream_ready", rgbReady_o, !(occ == 2 && !grayReady_i));
            if (!rgbReady_o) low_ready++;
            in_x  = rgbValid_i & rgbReady_o;
            out_x = grayValid_o & grayReady_i;
            if (grayValid_o) begin
                chk("stream_nonempty", q.size() > 0, 1);
                if (q.size() > 0) chk("stream_gray", GrayPixel_o, q[0]);
                chk("stream_last", lastPixel_o, (got % 9) == 8);
            end
            if (in_x) begin
                q.push_back(v);
                sent++;
            end
            prev_last = 1'b0;
            if (out_x) begin
                if (q.size() > 0) void'(q.pop_front());
                prev_last = ((got % 9) == 8);
                got++;
            end
            occ = occ + int'(in_x) - int'(out_x);
            @(posedge clk_i); #1;
            cyc++;
        end
        chk("stream_timeout", cyc < 300, 1);
        chk("stream_count", got, n);
        chk("stream_queue_empty", q.size(), 0);
        rgbValid_i = 1'b0;
    endtask

    initial begin
        int dones, gap, low_ready;
        rst_i        = 1'b0;
        RgbPixel_i   = '0;
        rgbValid_i   = 1'b0;
        frameClear_i = 1'b0;
        grayReady_i  = 1'b0;
        #1;
        chk("rst_gray", GrayPixel_o, 0);
        chk("rst_valid", grayValid_o, 0);
        chk("rst_last", lastPixel_o, 0);
        chk("rst_done", frameDone_o, 0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1 chk("rst_ready", rgbReady_o, 1);
        @(posedge clk_i); #1;

        single(8'd255, 8'd255, 8'd255, 8'd255, "white");
        single(8'd100, 8'd50,  8'd200, 8'd82,  "mixed");
        single(8'd255, 8'd0,   8'd0,   EXP_RED,  "red");
        single(8'd0,   8'd255, 8'd0,   8'd149,   "green");
        single(8'd0,   8'd0,   8'd255, EXP_BLUE, "blue");

        // Counter now at 5: fill both stages, then flush with a pixel offered.
        grayReady_i = 1'b0;
        rgbValid_i  = 1'b1;
        RgbPixel_i  = {3{8'd40}};
        #1 chk("fill1_ready", rgbReady_o, 1);
        @(posedge clk_i); #1;
        RgbPixel_i = {3{8'd41}};
        #1 chk("fill2_ready", rgbReady_o, 1);
        @(posedge clk_i); #1;
        RgbPixel_i = {3{8'd42}};
        #1 chk("full_ready", rgbReady_o, 0);
        chk("full_valid", grayValid_o, 1);
        chk("full_gray", GrayPixel_o, 40);
        @(posedge clk_i); #1;
        chk("hold_valid", grayValid_o, 1);
        chk("hold_gray", GrayPixel_o, 40);
        frameClear_i = 1'b1;
        grayReady_i  = 1'b1;
        #1 chk("clear_ready", rgbReady_o, 0);
        @(posedge clk_i); #1;
        frameClear_i = 1'b0;
        rgbValid_i   = 1'b0;
        chk("clear_valid", grayValid_o, 0);
        chk("clear_done", frameDone_o, 0);
        @(posedge clk_i); #1;
        chk("clear_s1_flushed", grayValid_o, 0);
        @(posedge clk_i); #1;
        chk("clear_s1_flushed2", grayValid_o, 0);

        run_stream(9, 1, dones, gap, low_ready);
        chk("bp_done_pulses", dones, 1);
        chk("bp_ready_low_seen", low_ready > 0, 1);

        run_stream(18, 0, dones, gap, low_ready);
        chk("b2b_done_pulses", dones, 2);
        chk("b2b_done_gap", gap, 9);

        // Reset in the middle of a frame.
        rgbValid_i  = 1'b1;
        grayReady_i = 1'b1;
        RgbPixel_i  = {3{8'd60}};
        repeat (3) @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        #1;
        chk("mid_rst_valid", grayValid_o, 0);
        chk("mid_rst_gray", GrayPixel_o, 0);
        chk("mid_rst_last", lastPixel_o, 0);
        rgbValid_i = 1'b0;
        @(posedge clk_i); #1;
        chk("mid_rst_done", frameDone_o, 0);
        @(posedge clk_i); #1;
        chk("mid_rst_done2", frameDone_o, 0);
        rst_i = 1'b1;
        #1 chk("post_rst_ready", rgbReady_o, 1);
        chk("post_rst_valid", grayValid_o, 0);
        @(posedge clk_i); #1;
        run_stream(9, 1, dones, gap, low_ready);
        chk("post_rst_done_pulses", dones, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
